// File: rtl/pipe_stage_buf_if.sv
// Valid/ready beat channel between pipeline stages: datapath payload plus control payload.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_buf_if #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 16
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (
      output valid,
      output data,
      output ctrl,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  ctrl,
      output ready
   );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer, flush and clk_en.
// Define PIPE_STAGE_STATS_EN to add saturating stall/bubble statistics counters and their ports.
module pipe_stage_buf #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clk_en,
   input  logic                  flush,
   pipe_stage_buf_if.slave       up,
   pipe_stage_buf_if.master      dn,
   output logic [1:0]            occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]      stat_stall_cnt,
   output logic [CNT_W-1:0]      stat_bubble_cnt
`endif
);

   if (SKID > 1) begin : g_bad_skid
      $error("pipe_stage_buf: SKID must be 0 or 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_buf: CNT_W must be at least 1");
   end

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

   logic main_v;
   logic skid_v;
   logic up_ready;
   logic acc;
   logic pop;

   always_comb begin
      main_v = (state_q != StEmpty);
      skid_v = (state_q == StTwo);
      // With SKID=0 there is no spare slot, so ready must look through to dn.ready.
      if (SKID == 0) begin
         up_ready = clk_en & ~flush & (~main_v | dn.ready);
      end else begin
         up_ready = clk_en & ~flush & ~skid_v;
      end
      acc = up.valid & up_ready;
      pop = main_v & dn.ready & clk_en;
   end

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (clk_en) begin
         if (flush) begin
            state_d = StEmpty;
         end else begin
            case (state_q)
               StEmpty: begin
                  if (acc) begin
                     main_data_d = up.data;
                     main_ctrl_d = up.ctrl;
                     state_d     = StOne;
                  end
               end
               StOne: begin
                  if (acc && pop) begin
                     main_data_d = up.data;
                     main_ctrl_d = up.ctrl;
                  end else if (acc) begin
                     skid_data_d = up.data;
                     skid_ctrl_d = up.ctrl;
                     state_d     = StTwo;
                  end else if (pop) begin
                     state_d = StEmpty;
                  end
               end
               StTwo: begin
                  if (pop) begin
                     main_data_d = skid_data_q;
                     main_ctrl_d = skid_ctrl_q;
                     state_d     = StOne;
                  end
               end
               default: state_d = StEmpty;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StEmpty;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   assign up.ready  = up_ready;
   assign dn.valid  = main_v;
   assign dn.data   = main_data_q;
   // Invalid beats present the all-zero NOP control word.
   assign dn.ctrl   = main_v ? main_ctrl_q : '0;
   assign occupancy = state_q;

`ifdef PIPE_STAGE_STATS_EN
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else if (clk_en) begin
         if (main_v && !dn.ready && (stall_q != '1)) begin
            stall_q <= stall_q + CntOne;
         end
         if (!main_v && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CntOne;
         end
      end
   end

   assign stat_stall_cnt  = stall_q;
   assign stat_bubble_cnt = bubble_q;
`endif

endmodule
